// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave target: FSM state encoding, ACK/NACK
// bus levels and the address-match helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    RACK,
    WAIT_STOP
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // The general call address (0) is never claimed, even if it happens to equal own_addr.
  function automatic logic addr_match(input logic [6:0] rx_addr, input logic [6:0] own_addr);
    return (rx_addr == own_addr) && (rx_addr != 7'd0);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the system clock domain and produces registered
// bus events.
//   clk, reset          system clock, async active-high reset
//   scl_in, sda_in      raw bus lines
//   sda                 synchronised SDA level, aligned with the event pulses
//   scl_rise, scl_fall  one-cycle SCL edge pulses
//   start_det, stop_det one-cycle START / STOP condition pulses
// Event latency from the pins is SYNC_STAGES+1 cycles.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_q;
  logic                   sda_q;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign sda   = sda_q;

  // Everything resets to the idle-bus level (both lines high) so releasing
  // reset never fabricates an edge or a START/STOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q     <= scl_s;
      sda_q     <= sda_s;
      scl_rise  <= scl_s & ~scl_q;
      scl_fall  <= ~scl_s & scl_q;
      // START/STOP require SCL high in both samples, so they can never
      // coincide with an SCL edge.
      start_det <= scl_s & scl_q & sda_q & ~sda_s;
      stop_det  <= scl_s & scl_q & ~sda_q & sda_s;
    end
  end

endmodule

// File: rtl/i2c_slave_target.sv
// Oversampled I2C slave target. SCL is sampled on clk, never used as a clock.
//   clk, reset  system clock (>= 4x SCL), async active-high reset
//   i2c_scl     bus clock from the master
//   i2c_sda_i   bus data seen by the target
//   i2c_sda_o   data driven by the target (1 = release, 0 = pull low)
//   rx_ready    local side accepts the incoming byte (0 -> NACK it)
//   rx_data     last accepted written byte, rx_valid pulses on update
//   tx_data     byte returned on master reads, consumed when tx_ack pulses
//   busy        addressed transfer in progress
//   rw_dir      R/W bit of the current transfer (1 = read)
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       busy,
  output logic       rw_dir
);

  logic       sda;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] byte_in;
  logic       phase;  // ack slot: 0 = not yet driven, 1 = driven / master ACK seen
  logic       resp;   // ACK/NACK level for the pending write-data ack slot

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (i2c_scl),
    .sda_in   (i2c_sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  always_comb begin
    byte_in = {shreg[6:0], sda};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      phase     <= 1'b0;
      resp      <= I2C_NACK;
      i2c_sda_o <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_ack    <= 1'b0;
      busy      <= 1'b0;
      rw_dir    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      if (stop_det) begin
        state     <= IDLE;
        i2c_sda_o <= 1'b1;
        busy      <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        phase     <= 1'b0;
        i2c_sda_o <= 1'b1;
      end else begin
        case (state)
          IDLE: ;

          ADDR: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr_match(byte_in[7:1], SLAVE_ADDR)) begin
                rw_dir <= byte_in[0];
                busy   <= 1'b1;
                phase  <= 1'b0;
                state  <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end
          end

          ADDR_ACK: if (scl_fall) begin
            if (!phase) begin
              i2c_sda_o <= I2C_ACK;
              phase     <= 1'b1;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= '0;
              if (rw_dir) begin
                tx_ack    <= 1'b1;
                shreg     <= tx_data;
                i2c_sda_o <= tx_data[7];
                state     <= RDATA;
              end else begin
                i2c_sda_o <= 1'b1;
                state     <= WDATA;
              end
            end
          end

          WDATA: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              phase <= 1'b0;
              state <= WACK;
              if (rx_ready) begin
                rx_data  <= byte_in;
                rx_valid <= 1'b1;
                resp     <= I2C_ACK;
              end else begin
                resp <= I2C_NACK;
              end
            end
          end

          WACK: if (scl_fall) begin
            if (!phase) begin
              i2c_sda_o <= resp;
              phase     <= 1'b1;
            end else begin
              i2c_sda_o <= 1'b1;
              phase     <= 1'b0;
              bit_cnt   <= '0;
              if (resp == I2C_ACK) begin
                state <= WDATA;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end
          end

          // shreg[7] is always the bit currently on the bus; bit_cnt counts
          // rises and wraps to 0 after the 8th, marking the end of the byte.
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                i2c_sda_o <= 1'b1;
                phase     <= 1'b0;
                state     <= RACK;
              end else begin
                i2c_sda_o <= shreg[6];
                shreg     <= {shreg[6:0], 1'b0};
              end
            end
          end

          RACK: begin
            if (scl_rise) begin
              if (sda == I2C_ACK) begin
                phase <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end else if (scl_fall && phase) begin
              phase     <= 1'b0;
              bit_cnt   <= '0;
              tx_ack    <= 1'b1;
              shreg     <= tx_data;
              i2c_sda_o <= tx_data[7];
              state     <= RDATA;
            end
          end

          WAIT_STOP: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: 100 MHz system clock, 1 MHz SCL bus
// master model, wired-AND SDA.
module tb_i2c_slave_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       dut_sda;
  logic       sda_line;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       busy;
  logic       rw_dir;

  int         n_cmp = 0;
  int         n_err = 0;
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         low_cnt = 0;
  int         tx_base = 0;
  logic [7:0] tx_tbl [0:3];

  assign sda_line = m_sda & dut_sda;
  assign tx_data  = tx_tbl[(tx_cnt - tx_base) & 3];

  always #5 clk = ~clk;

  i2c_slave_target #(
    .SLAVE_ADDR (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i2c_scl  (scl),
    .i2c_sda_i(sda_line),
    .i2c_sda_o(dut_sda),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .busy     (busy),
    .rw_dir   (rw_dir)
  );

  always @(posedge clk) begin
    if (rx_valid) rx_cnt <= rx_cnt + 1;
    if (tx_ack) tx_cnt <= tx_cnt + 1;
    if (dut_sda === 1'b0) low_cnt <= low_cnt + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SCL period; returns the SDA line level sampled mid-high.
  task automatic bit_xfer(input logic b, output logic seen);
    m_sda = b;
    #250ns scl = 1'b1;
    #250ns seen = sda_line;
    #250ns scl = 1'b0;
    #250ns;
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    #250ns scl = 1'b1;
    #250ns m_sda = 1'b0;
    #250ns scl = 1'b0;
    #250ns;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    #250ns scl = 1'b1;
    #250ns m_sda = 1'b1;
    #500ns;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(m_ack, s);
  endtask

  initial begin
    logic       a0, a1;
    logic [7:0] d0, d1;
    logic       s;
    int         rx0, tx0, low0;

    // Reset values
    #100ns;
    chk("rst_sda_o", dut_sda, 1'b1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_ack", tx_ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rw_dir", rw_dir, 1'b0);
    reset = 1'b0;
    #1us;

    // Write 0x50/W, 0xA5
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'hA0, a0);
    chk("w_addr_ack", a0, 1'b0);
    chk("w_busy_mid", busy, 1'b1);
    chk("w_rw_dir", rw_dir, 1'b0);
    send_byte(8'hA5, a1);
    chk("w_data_ack", a1, 1'b0);
    bus_stop();
    chk("w_rx_data", rx_data, 8'hA5);
    chk("w_rx_pulses", rx_cnt - rx0, 1);
    chk("w_busy_end", busy, 1'b0);

    // Address 0x51 mismatch
    rx0 = rx_cnt; low0 = low_cnt;
    bus_start();
    send_byte(8'hA2, a0);
    chk("mm_addr_nack", a0, 1'b1);
    chk("mm_busy", busy, 1'b0);
    send_byte(8'h55, a1);
    chk("mm_data_nack", a1, 1'b1);
    bus_stop();
    chk("mm_sda_low_cycles", low_cnt - low0, 0);
    chk("mm_rx_pulses", rx_cnt - rx0, 0);
    chk("mm_rx_data", rx_data, 8'hA5);

    // Read 0x50/R: 0x3C (master ACK), 0xC3 (master NACK)
    tx_tbl[0] = 8'h3C; tx_tbl[1] = 8'hC3; tx_tbl[2] = 8'hFF; tx_tbl[3] = 8'hFF;
    tx_base = tx_cnt; tx0 = tx_cnt;
    bus_start();
    send_byte(8'hA1, a0);
    chk("r_addr_ack", a0, 1'b0);
    chk("r_rw_dir", rw_dir, 1'b1);
    read_byte(1'b0, d0);
    chk("r_byte0", d0, 8'h3C);
    read_byte(1'b1, d1);
    chk("r_byte1", d1, 8'hC3);
    chk("r_busy_after_nack", busy, 1'b0);
    chk("r_sda_released", dut_sda, 1'b1);
    bus_stop();
    chk("r_tx_ack_pulses", tx_cnt - tx0, 2);

    // Write with rx_ready=0 -> data NACK, then bus ignored until STOP
    rx_ready = 1'b0;
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'hA0, a0);
    chk("nr_addr_ack", a0, 1'b0);
    send_byte(8'h11, a1);
    chk("nr_data_nack", a1, 1'b1);
    chk("nr_busy", busy, 1'b0);
    low0 = low_cnt;
    send_byte(8'h00, a1);
    chk("nr_wait_stop_nack", a1, 1'b1);
    chk("nr_wait_stop_low", low_cnt - low0, 0);
    bus_stop();
    chk("nr_rx_data", rx_data, 8'hA5);
    chk("nr_rx_pulses", rx_cnt - rx0, 0);
    rx_ready = 1'b1;

    // Write 0x22, repeated START, read one byte
    tx_tbl[0] = 8'h5A;
    tx_base = tx_cnt;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h22, a1);
    chk("rs_write_ack", {a0, a1}, 2'b00);
    bus_start();
    chk("rs_busy_held", busy, 1'b1);
    send_byte(8'hA1, a0);
    chk("rs_addr_ack", a0, 1'b0);
    chk("rs_rw_dir", rw_dir, 1'b1);
    chk("rs_rx_data", rx_data, 8'h22);
    read_byte(1'b1, d0);
    chk("rs_read_byte", d0, 8'h5A);
    bus_stop();

    // Reset after 4 address bits
    bus_start();
    for (int i = 7; i >= 4; i--) begin
      d0 = 8'hA0;
      bit_xfer(d0[i], s);
    end
    reset = 1'b1;
    #1ns;
    chk("rst4_sda_o", dut_sda, 1'b1);
    chk("rst4_busy", busy, 1'b0);
    chk("rst4_rx_data", rx_data, 8'h00);
    #99ns reset = 1'b0;
    bus_stop();

    // Reset while the target is pulling SDA low for the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      d0 = 8'hA0;
      bit_xfer(d0[i], s);
    end
    m_sda = 1'b1;
    #250ns scl = 1'b1;
    #100ns;
    chk("rsta_sda_before", dut_sda, 1'b0);
    chk("rsta_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1ns;
    chk("rsta_sda_same_cycle", dut_sda, 1'b1);
    chk("rsta_busy", busy, 1'b0);
    #99ns reset = 1'b0;
    #50ns scl = 1'b0;
    #250ns;
    bus_stop();

    // Full write after reset
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h7E, a1);
    chk("pr_acks", {a0, a1}, 2'b00);
    bus_stop();
    chk("pr_rx_data", rx_data, 8'h7E);
    chk("pr_rx_pulses", rx_cnt - rx0, 1);
    chk("pr_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
